// File: rtl/ma_stage_lsu.sv
// Memory-access pipeline stage: word load/store over a req/ack bus, pipeline stall
// while a transaction is outstanding, and the registered MA/WB writeback boundary.
module ma_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  M_sel_result,
  input  logic        M_we_dm,
  input  logic        M_we_rf,
  input  logic [31:0] M_alu_o,
  input  logic [31:0] M_dm_wd,
  input  logic [4:0]  M_rf_a3,
  input  logic [31:0] M_PC_P4,
  input  logic [31:0] M_ext,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        err,
  output logic        W_we_rf,
  output logic [4:0]  W_rf_a3,
  output logic [31:0] W_result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          timed_out;

  logic        store, load, mem_op, misaligned, start, wb_kill;
  logic [31:0] load_src, result_mux;

  assign store      = M_we_dm;
  assign load       = (M_sel_result == 2'b01) & ~M_we_dm;
  assign mem_op     = load | store;
  assign misaligned = mem_op & (M_alu_o[1:0] != 2'b00);
  assign start      = (state == IDLE) & mem_op & ~misaligned;
  assign stall      = start | (state == BUSY);

  // A load that never got valid data must not reach the register file.
  assign wb_kill  = load & (((state == IDLE) & misaligned) | ((state == DONE) & timed_out));
  assign load_src = (state == DONE) ? rdata_q : 32'h0;

  always_comb begin
    result_mux = M_alu_o;
    case (M_sel_result)
      2'b00:   result_mux = M_alu_o;
      2'b01:   result_mux = load_src;
      2'b10:   result_mux = M_PC_P4;
      default: result_mux = M_ext;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= 32'h0;
      timed_out <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= {M_alu_o[31:2], 2'b00};
            mem_we    <= store;
            mem_wdata <= M_dm_wd;
            mem_req   <= 1'b1;
            cnt       <= '0;
            timed_out <= 1'b0;
            state     <= BUSY;
          end else if (misaligned) begin
            err <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (load) rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            rdata_q   <= 32'h0;
            err       <= 1'b1;
            timed_out <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stalled cycles insert a bubble but leave the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_we_rf  <= 1'b0;
      W_rf_a3  <= 5'd0;
      W_result <= 32'h0;
    end else if (stall) begin
      W_we_rf <= 1'b0;
    end else begin
      W_we_rf  <= M_we_rf & ~wb_kill;
      W_rf_a3  <= M_rf_a3;
      W_result <= result_mux;
    end
  end

endmodule

// File: tb/tb_ma_stage_lsu.sv
// Directed bench for ma_stage_lsu (TIMEOUT=4): ALU, load, store, misaligned,
// timeout and reset-during-BUSY cases with hand-computed expectations.
module tb_ma_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  M_sel_result = 2'b00;
  logic        M_we_dm = 1'b0;
  logic        M_we_rf = 1'b0;
  logic [31:0] M_alu_o = 32'h0;
  logic [31:0] M_dm_wd = 32'h0;
  logic [4:0]  M_rf_a3 = 5'd0;
  logic [31:0] M_PC_P4 = 32'h0;
  logic [31:0] M_ext = 32'h0;
  logic        mem_req, mem_we, stall, err, W_we_rf;
  logic [31:0] mem_addr, mem_wdata, W_result;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [4:0]  W_rf_a3;

  int checks = 0;
  int errors = 0;

  ma_stage_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_sel_result(M_sel_result), .M_we_dm(M_we_dm), .M_we_rf(M_we_rf),
    .M_alu_o(M_alu_o), .M_dm_wd(M_dm_wd), .M_rf_a3(M_rf_a3),
    .M_PC_P4(M_PC_P4), .M_ext(M_ext),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .err(err),
    .W_we_rf(W_we_rf), .W_rf_a3(W_rf_a3), .W_result(W_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] sel, input logic we_dm, input logic we_rf,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] a3,
                           input logic [31:0] ext);
    M_sel_result = sel;
    M_we_dm      = we_dm;
    M_we_rf      = we_rf;
    M_alu_o      = alu;
    M_dm_wd      = wd;
    M_rf_a3      = a3;
    M_PC_P4      = 32'h0000_0804;
    M_ext        = ext;
  endtask

  // Runs from the instruction's first cycle until the first non-stalled cycle.
  // ack_dly<0 means the bus never acknowledges.
  task automatic mem_access(input int ack_dly, input logic [31:0] rdata,
                            output int n_stall, output int n_req, output int n_err,
                            output logic [31:0] addr, output logic we, output logic [31:0] wdata);
    int   req_age;
    logic seen, finished;
    n_stall = 0; n_req = 0; n_err = 0; req_age = 0;
    seen = 1'b0; finished = 1'b0;
    addr = 32'h0; we = 1'b0; wdata = 32'h0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      mem_ack   = mem_req && (ack_dly >= 0) && (req_age == ack_dly);
      mem_rdata = mem_ack ? rdata : 32'h5A5A_5A5A;
      #1;
      if (mem_req) begin
        if (!seen) begin
          addr = mem_addr; we = mem_we; wdata = mem_wdata; seen = 1'b1;
        end
        n_req++;
        req_age++;
      end
      if (err) n_err++;
      if (!stall) begin
        finished = 1'b1;
        break;
      end
      n_stall++;
      @(posedge clk);
      #1;
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check("stall_bound", {31'd0, finished}, 32'd1);
  endtask

  int          ns, nr, ne;
  logic [31:0] a, wd;
  logic        w;

  initial begin
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_W_we_rf", {31'd0, W_we_rf}, 32'd0);
    check("rst_W_result", W_result, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ALU op
    set_instr(2'b00, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd5, 32'h0);
    #1;
    check("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    check("alu_W_we_rf", {31'd0, W_we_rf}, 32'd1);
    check("alu_W_rf_a3", {27'd0, W_rf_a3}, 32'd5);
    check("alu_W_result", W_result, 32'h0000_1234);
    $display("txn alu: W_result=0x%08h", W_result);

    // Load at 0x100, ack one cycle after mem_req rises
    set_instr(2'b01, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 32'h0);
    mem_access(1, 32'hDEAD_BEEF, ns, nr, ne, a, w, wd);
    check("ld_stall_cycles", ns, 32'd3);
    check("ld_req_cycles", nr, 32'd2);
    check("ld_addr", a, 32'h0000_0100);
    check("ld_we", {31'd0, w}, 32'd0);
    check("ld_err", ne, 32'd0);
    tick();
    check("ld_W_we_rf", {31'd0, W_we_rf}, 32'd1);
    check("ld_W_rf_a3", {27'd0, W_rf_a3}, 32'd7);
    check("ld_W_result", W_result, 32'hDEAD_BEEF);
    $display("txn load 0x100: stall=%0d req=%0d W_result=0x%08h", ns, nr, W_result);
    set_instr(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    tick();
    check("ld_W_we_rf_once", {31'd0, W_we_rf}, 32'd0);

    // Store 0xCAFEF00D to 0x204, immediate ack
    set_instr(2'b00, 1'b1, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 5'd9, 32'h0);
    mem_access(0, 32'h0, ns, nr, ne, a, w, wd);
    check("st_stall_cycles", ns, 32'd2);
    check("st_req_cycles", nr, 32'd1);
    check("st_addr", a, 32'h0000_0204);
    check("st_we", {31'd0, w}, 32'd1);
    check("st_wdata", wd, 32'hCAFE_F00D);
    check("st_err", ne, 32'd0);
    tick();
    check("st_W_we_rf", {31'd0, W_we_rf}, 32'd0);
    check("st_W_result", W_result, 32'h0000_0204);
    check("st_err_after", {31'd0, err}, 32'd0);
    $display("txn store 0x204: stall=%0d wdata=0x%08h", ns, wd);

    // Misaligned load at 0x102
    set_instr(2'b01, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 5'd3, 32'h0);
    mem_access(0, 32'h1111_1111, ns, nr, ne, a, w, wd);
    check("mis_stall_cycles", ns, 32'd0);
    check("mis_req_cycles", nr, 32'd0);
    tick();
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_W_we_rf", {31'd0, W_we_rf}, 32'd0);
    check("mis_mem_req", {31'd0, mem_req}, 32'd0);
    set_instr(2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    tick();
    check("mis_err_one_cycle", {31'd0, err}, 32'd0);
    check("pc4_W_result", W_result, 32'h0000_0804);
    $display("txn misaligned load 0x102: err pulse seen");

    // Timeout (no ack)
    set_instr(2'b01, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd4, 32'h0);
    mem_access(-1, 32'h0, ns, nr, ne, a, w, wd);
    check("to_stall_cycles", ns, 32'd5);
    check("to_req_cycles", nr, 32'd4);
    check("to_err_in_done", ne, 32'd1);
    tick();
    check("to_W_we_rf", {31'd0, W_we_rf}, 32'd0);
    check("to_W_result", W_result, 32'h0);
    check("to_err_cleared", {31'd0, err}, 32'd0);
    $display("txn timeout load 0x40: stall=%0d req=%0d", ns, nr);

    // Reset while BUSY, late ack ignored, then LUI
    set_instr(2'b01, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd6, 32'h0);
    tick();
    check("rb_mem_req_busy", {31'd0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rb_mem_req_async", {31'd0, mem_req}, 32'd0);
    set_instr(2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 5'd10, 32'h1234_5000);
    tick();
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("rb_stall", {31'd0, stall}, 32'd0);
    tick();
    mem_ack   = 1'b0;
    check("rb_mem_req", {31'd0, mem_req}, 32'd0);
    check("lui_W_we_rf", {31'd0, W_we_rf}, 32'd1);
    check("lui_W_rf_a3", {27'd0, W_rf_a3}, 32'd10);
    check("lui_W_result", W_result, 32'h1234_5000);
    $display("txn reset-in-busy then lui: W_result=0x%08h", W_result);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ma_stage_lsu.md
# ma_stage_lsu

Memory-access stage unit of the five-stage pipeline. It sits between the EX/MA pipeline register and the register-file write port. It consumes the MA-stage control and data fields and runs word loads and stores over a req/ack data-memory bus. It stalls the pipeline while a bus transaction is outstanding and registers the selected writeback result into the MA/WB boundary.

## Interface
- TIMEOUT, 16: max BUSY cycles without mem_ack before the access is aborted (≥2).
- clk  input  1  pipeline clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- M_sel_result  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 immediate (LUI)
- M_we_dm  input  1  store request
- M_we_rf  input  1  register write enable
- M_alu_o  input  32  ALU result / memory address
- M_dm_wd  input  32  store data
- M_rf_a3  input  5  destination register
- M_PC_P4  input  32  PC+4
- M_ext  input  32  immediate
- mem_req  output  1  bus request, registered
- mem_we  output  1  1 = write, registered
- mem_addr  output  32  word address, registered
- mem_wdata  output  32  write data, registered
- mem_rdata  input  32  read data, valid when mem_ack=1
- mem_ack  input  1  one-cycle completion pulse
- stall  output  1  freezes the PC and the IF/ID, ID/EX and EX/MA registers (combinational)
- err  output  1  one-cycle pulse: misaligned access or timeout (registered)
- W_we_rf  output  1  writeback enable
- W_rf_a3  output  5  writeback register
- W_result  output  32  writeback data

## Operation
- Memory-op decode:
  - store = M_we_dm.
  - load = (M_sel_result==01) & ~M_we_dm; store has priority.
  - mem_op = load | store.
- Misaligned (M_alu_o[1:0]≠00) with mem_op:
  - no bus access and no stall; err pulses next cycle.
  - The store is dropped.
  - A load writes back W_we_rf=0.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - On an aligned mem_op: stall=1; load mem_addr={M_alu_o[31:2],2'b00}, mem_we=store, mem_wdata=M_dm_wd; mem_req←1; go to BUSY; clear the timeout counter.
  - Otherwise stall=0.
- BUSY:
  - stall=1 and mem_req held at 1.
  - On mem_ack: rdata_q←mem_rdata (for a load), mem_req←0, go to DONE.
  - Otherwise count up. When the count reaches TIMEOUT-1: mem_req←0, rdata_q←0, err←1, go to DONE.
- DONE:
  - stall=0; the instruction retires this edge; go to IDLE.
  - If the access timed out, a load writes back with W_we_rf=0.
- Writeback register, updated every cycle:
  - While stall=1: W_we_rf←0 (bubble). W_rf_a3 and W_result keep their previous values.
  - Otherwise: W_we_rf←M_we_rf (except the suppression cases above), W_rf_a3←M_rf_a3, W_result←mux(M_sel_result).
  - The load source is rdata_q in DONE, and 0 in the misaligned case.
- mem_ack outside BUSY is ignored.
- mem_rdata is not sampled except on ack in BUSY.
- A store's W_result follows M_sel_result as normal (RF write normally 0).

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, W_we_rf=0, W_rf_a3=0, W_result=0, rdata_q=0, counter=0.
  - Any outstanding request is abandoned; a late ack after reset is ignored.
- Non-memory instruction: one cycle, no stall; W_* valid the cycle after it is presented.
- Aligned load/store with ack k cycles after mem_req rises (k≥0):
  - stall is high for k+2 cycles (IDLE cycle + k+1 BUSY cycles).
  - W_* updates on the DONE edge.
  - Minimum latency is 3 cycles for an ack in the first BUSY cycle.
- mem_req rises on the edge leaving IDLE. It falls on the edge at which ack is sampled, or on the timeout edge.
- Timeout: err is high for exactly one cycle, the DONE cycle. Total stall is TIMEOUT+1 cycles.
- Back-to-back memory ops: the second starts in the IDLE cycle following DONE. There is no overlap of transactions.

## Test plan
- ALU op: M_sel_result=00, M_alu_o=0x1234, M_we_rf=1, M_rf_a3=5 -> next cycle W_we_rf=1, W_rf_a3=5, W_result=0x1234, stall never asserted.
- Load at 0x100 with ack and mem_rdata=0xDEADBEEF one cycle after mem_req -> mem_req high 2 cycles, mem_addr=0x100, mem_we=0, stall high 3 cycles, then W_result=0xDEADBEEF and W_we_rf=1 once.
- Store 0xCAFEF00D to 0x204, immediate ack -> mem_we=1, mem_wdata=0xCAFEF00D, stall 2 cycles, W_we_rf=0, no err.
- Misaligned load at 0x102 -> no mem_req, no stall, err one cycle, W_we_rf=0.
- No ack, TIMEOUT=4 -> mem_req high 4 cycles, stall 5 cycles, err pulse in DONE, load W_we_rf=0.
- rst_n low while in BUSY -> mem_req=0 immediately; ack after release ignored; next LUI (sel 11, M_ext=0x12345000) writes W_result=0x12345000.
